// File: rtl/sc_regarbiter_pkg.sv
// sc_regarbiter_pkg: shared state encoding and operation codes for the register strobe arbiter
//   no ports; imported by sc_regarbiter and sc_rrpick
package sc_regarbiter_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] GUARD  = 2'd3;
    localparam logic OP_CLEAR = 1'b1;
    localparam logic OP_LOAD  = 1'b0;
endpackage

// File: rtl/sc_rrpick.sv
// sc_rrpick: combinational 2-way picker, clear beats load, round-robin on equal ops
//   eligible[1:0] in  requesters currently allowed to win
//   op[1:0]       in  per-requester operation (OP_CLEAR / OP_LOAD)
//   lastWinner    in  index of the most recently served requester
//   valid         out at least one requester is eligible
//   winner        out index of the chosen requester
module sc_rrpick
    import sc_regarbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic [1:0] op,
    input  logic       lastWinner,
    output logic       valid,
    output logic       winner
);
    assign valid = |eligible;
    // With a single candidate its index is eligible[1]; on a tie of equal ops the
    // requester that did not win last time goes first.
    assign winner = (eligible == 2'b11)
                  ? ((op[0] != op[1]) ? (op[1] == OP_CLEAR) : ~lastWinner)
                  : eligible[1];
endmodule

// File: rtl/sc_regarbiter.sv
// sc_regarbiter: sequences clear/load strobes for the shared register from two requesters
//   SC_REGARBITER_CLOCK_50      in  system clock, rising edge
//   SC_REGARBITER_RESET_InLow   in  synchronous active-low reset
//   SC_REGARBITER_req0/1_InLow  in  request, held low until ack
//   SC_REGARBITER_op0/1_In      in  operation, 1 = clear, 0 = load
//   SC_REGARBITER_ack0/1_OutLow out one-cycle served pulse
//   SC_REGARBITER_clear_OutLow  out register clear strobe
//   SC_REGARBITER_load_OutLow   out register load strobe
//   SC_REGARBITER_sel_Out       out register mux select (granted requester)
//   SC_REGARBITER_busy_OutHigh  out high whenever not idle
module sc_regarbiter
    import sc_regarbiter_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int GUARD_WIDTH  = 4
) (
    input  logic SC_REGARBITER_CLOCK_50,
    input  logic SC_REGARBITER_RESET_InLow,
    input  logic SC_REGARBITER_req0_InLow,
    input  logic SC_REGARBITER_op0_In,
    input  logic SC_REGARBITER_req1_InLow,
    input  logic SC_REGARBITER_op1_In,
    output logic SC_REGARBITER_ack0_OutLow,
    output logic SC_REGARBITER_ack1_OutLow,
    output logic SC_REGARBITER_clear_OutLow,
    output logic SC_REGARBITER_load_OutLow,
    output logic SC_REGARBITER_sel_Out,
    output logic SC_REGARBITER_busy_OutHigh
);
    logic [1:0] state, nextState;
    logic [1:0] armed, reqLow, reqOp;
    logic lastWinner, winner, opReg, pickValid, pickWinner;
    logic [GUARD_WIDTH-1:0] guardCnt;

    assign reqLow = ~{SC_REGARBITER_req1_InLow, SC_REGARBITER_req0_InLow};
    assign reqOp  = {SC_REGARBITER_op1_In, SC_REGARBITER_op0_In};

    sc_rrpick uPick (
        .eligible  (armed & reqLow),
        .op        (reqOp),
        .lastWinner(lastWinner),
        .valid     (pickValid),
        .winner    (pickWinner)
    );

    always_ff @(posedge SC_REGARBITER_CLOCK_50) begin
        if (!SC_REGARBITER_RESET_InLow) begin
            state      <= IDLE;
            armed      <= 2'b11;
            lastWinner <= 1'b1;
            winner     <= 1'b0;
            opReg      <= OP_LOAD;
            guardCnt   <= '0;
        end else begin
            state <= nextState;
            // Re-arm on a released request; disarming the served requester takes
            // precedence so a held request yields exactly one operation.
            armed <= armed | ~reqLow;
            if (state == STROBE) begin
                armed[winner] <= 1'b0;
                lastWinner    <= winner;
                guardCnt      <= GUARD_WIDTH'(GUARD_CYCLES - 1);
            end else if (state == GUARD && guardCnt != '0)
                guardCnt <= guardCnt - GUARD_WIDTH'(1);
            if (state == IDLE && pickValid) begin
                winner <= pickWinner;
                opReg  <= reqOp[pickWinner];
            end
        end
    end

    always_comb begin
        nextState = (state == IDLE)   ? (pickValid ? SETUP : IDLE)
                  : (state == SETUP)  ? STROBE
                  : (state == STROBE) ? ((GUARD_CYCLES > 0) ? GUARD : IDLE)
                  : ((guardCnt == '0) ? IDLE : GUARD);
    end

    always_comb begin
        SC_REGARBITER_clear_OutLow = !(state == STROBE && opReg == OP_CLEAR);
        SC_REGARBITER_load_OutLow  = !(state == STROBE && opReg == OP_LOAD);
        SC_REGARBITER_ack0_OutLow  = !(state == STROBE && !winner);
        SC_REGARBITER_ack1_OutLow  = !(state == STROBE && winner);
        SC_REGARBITER_sel_Out      = winner;
        SC_REGARBITER_busy_OutHigh = (state != IDLE);
    end
endmodule

// File: tb/tb_sc_regarbiter.sv
// tb_sc_regarbiter: random requesters against a service-timeline model, scoreboarded strobes
module tb_sc_regarbiter;
    typedef struct {
        int   stamp;
        logic win;
        logic op;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [1:0] rqn [2];
    logic [1:0] opv [2];
    logic clrn [2], ldn [2], a0n [2], a1n [2], sel [2], busy [2];
    int checks = 0, errors = 0, cyc = 0;
    bit rnd = 1'b0;
    bit post [2][2];
    int hold [2][2];

    // model: mt = cycles since grant (0 idle, 1 setup, 2 strobe, 3.. guard)
    int   gc [2] = '{2, 0};
    int   mt [2] = '{0, 0};
    logic [1:0] marm [2] = '{2'b11, 2'b11};
    logic mlw [2] = '{1'b1, 1'b1};
    logic mwin [2] = '{1'b0, 1'b0};
    exp_t qa [$];
    exp_t qb [$];

    always #5 clk = ~clk;

    sc_regarbiter #(.GUARD_CYCLES(2), .GUARD_WIDTH(4)) dutA (
        .SC_REGARBITER_CLOCK_50(clk), .SC_REGARBITER_RESET_InLow(rstn),
        .SC_REGARBITER_req0_InLow(rqn[0][0]), .SC_REGARBITER_op0_In(opv[0][0]),
        .SC_REGARBITER_req1_InLow(rqn[0][1]), .SC_REGARBITER_op1_In(opv[0][1]),
        .SC_REGARBITER_ack0_OutLow(a0n[0]), .SC_REGARBITER_ack1_OutLow(a1n[0]),
        .SC_REGARBITER_clear_OutLow(clrn[0]), .SC_REGARBITER_load_OutLow(ldn[0]),
        .SC_REGARBITER_sel_Out(sel[0]), .SC_REGARBITER_busy_OutHigh(busy[0]));

    sc_regarbiter #(.GUARD_CYCLES(0), .GUARD_WIDTH(4)) dutB (
        .SC_REGARBITER_CLOCK_50(clk), .SC_REGARBITER_RESET_InLow(rstn),
        .SC_REGARBITER_req0_InLow(rqn[1][0]), .SC_REGARBITER_op0_In(opv[1][0]),
        .SC_REGARBITER_req1_InLow(rqn[1][1]), .SC_REGARBITER_op1_In(opv[1][1]),
        .SC_REGARBITER_ack0_OutLow(a0n[1]), .SC_REGARBITER_ack1_OutLow(a1n[1]),
        .SC_REGARBITER_clear_OutLow(clrn[1]), .SC_REGARBITER_load_OutLow(ldn[1]),
        .SC_REGARBITER_sel_Out(sel[1]), .SC_REGARBITER_busy_OutHigh(busy[1]));

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", name, d, cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return d ? qb.size() : qa.size();
    endfunction

    task automatic qpop(input int d, output exp_t e);
        if (d) e = qb.pop_front(); else e = qa.pop_front();
    endtask

    task automatic model_step(input int d);
        logic [1:0] el, req, op;
        logic w;
        exp_t e;
        req = rqn[d];
        op  = opv[d];
        if (!rstn) begin
            if (mt[d] == 1) begin
                if (d) void'(qb.pop_back()); else void'(qa.pop_back());
            end
            mt[d] = 0; marm[d] = 2'b11; mlw[d] = 1'b1; mwin[d] = 1'b0;
            return;
        end
        el = marm[d] & ~req;
        marm[d] = marm[d] | req;
        if (mt[d] == 0) begin
            if (el != 2'b00) begin
                if (el != 2'b11) w = el[1];
                else if (op[0] != op[1]) w = op[1];
                else w = !mlw[d];
                mwin[d] = w;
                mt[d] = 1;
                e.stamp = cyc + 1; e.win = w; e.op = op[w];
                if (d) qb.push_back(e); else qa.push_back(e);
            end
        end else if (mt[d] == 1) mt[d] = 2;
        else if (mt[d] == 2) begin
            marm[d][mwin[d]] = 1'b0;
            mlw[d] = mwin[d];
            mt[d] = (gc[d] > 0) ? 3 : 0;
        end else mt[d] = (mt[d] == 2 + gc[d]) ? 0 : mt[d] + 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, int'(busy[d]), int'(mt[d] != 0));
                chk("sel", d, int'(sel[d]), int'(mwin[d]));
                if (!clrn[d] || !ldn[d] || !a0n[d] || !a1n[d]) begin
                    if (qsize(d) == 0) chk("unexpected_strobe", d, 1, 0);
                    else begin
                        qpop(d, e);
                        chk("strobe_cycle", d, cyc, e.stamp);
                        chk("ack_pattern", d, int'({a1n[d], a0n[d]}), e.win ? 1 : 2);
                        chk("strobe_pattern", d, int'({clrn[d], ldn[d]}), e.op ? 1 : 2);
                    end
                end else if (qsize(d) > 0 && (d ? qb[0].stamp : qa[0].stamp) <= cyc) begin
                    qpop(d, e);
                    chk("strobe_present", d, 0, 1);
                end
            end
        end
    end

    task automatic tick();
        logic ack;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                ack = i ? a1n[d] : a0n[d];
                if (post[d][i]) begin
                    if (hold[d][i] == 0) begin
                        rqn[d][i] = 1'b1;
                        post[d][i] = 1'b0;
                    end else hold[d][i]--;
                end else if (!rqn[d][i]) begin
                    if (!ack) begin
                        post[d][i] = 1'b1;
                        hold[d][i] = !rnd ? 0 : ($urandom_range(0, 7) == 0)
                                   ? int'($urandom_range(5, 20)) : int'($urandom_range(0, 2));
                    end
                end else if (rnd && $urandom_range(0, 3) == 0) begin
                    rqn[d][i] = 1'b0;
                    opv[d][i] = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    initial begin
        int k;
        rqn = '{2'b11, 2'b11};
        opv = '{2'b00, 2'b00};
        post = '{'{0, 0}, '{0, 0}};
        hold = '{'{0, 0}, '{0, 0}};
        repeat (2) tick();
        rstn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rqn[d][0] = 1'b0;
            opv[d][0] = 1'b0;
        end
        repeat (10) tick();
        for (int d = 0; d < 2; d++) begin
            rqn[d] = 2'b00;
            opv[d] = 2'b10;
        end
        repeat (15) tick();
        rnd = 1'b1;
        for (int r = 0; r < 6; r++) begin
            repeat (400) tick();
            k = 0;
            while (a0n[0] && a1n[0] && k < 100) begin
                tick();
                k++;
            end
            chk("strobe_seen_for_reset", 0, int'(k < 100), 1);
            rstn = 1'b0;
            tick();
            rstn = 1'b1;
        end
        rnd = 1'b0;
        repeat (60) tick();
        chk("queue_drained", 0, qa.size(), 0);
        chk("queue_drained", 1, qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
